// File: rtl/frame_buffer_ctrl.sv
// rtl/frame_buffer_ctrl.sv - write-then-drain frame buffer with written-flag masking
// Upstream fills entries while idle; a drain streams every index in order, unwritten entries read as zero.
module frame_buffer_ctrl #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [15:0]   out,
  input  logic [15:0]   address,
  input  logic          rd_start,
  input  logic          rd_ready,
  output logic          rd_valid,
  output logic [15:0]   rd_data,
  output logic [AW-1:0] rd_index,
  output logic          rd_last,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   fill_cnt,
  output logic [7:0]    drop_cnt
);

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t           state_q, state_d;
  logic [15:0]      mem [DEPTH];
  logic [DEPTH-1:0] written;
  logic [AW-1:0]    idx;
  logic             addr_ok, wr_en, drop, hs, last_beat;

  assign addr_ok   = (address[15:AW] == '0);
  assign wr_en     = load && addr_ok && (state_q == IDLE);
  assign drop      = load && !wr_en;
  assign last_beat = (idx == LAST_IDX);
  assign hs        = (state_q == PRESENT) && rd_ready;

  assign rd_valid = (state_q == PRESENT);
  assign busy     = (state_q != IDLE);
  assign rd_index = idx;
  assign rd_last  = rd_valid && last_beat;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rd_start) state_d = FETCH;
      FETCH:   state_d = PRESENT;
      PRESENT: if (rd_ready) state_d = last_beat ? IDLE : FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx      <= '0;
      written  <= '0;
      fill_cnt <= '0;
      drop_cnt <= '0;
      rd_data  <= '0;
      done     <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= hs && last_beat;
      if (wr_en) begin
        written[address[AW-1:0]] <= 1'b1;
        if (!written[address[AW-1:0]]) fill_cnt <= fill_cnt + 1'b1;
      end
      if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 1'b1;
      if ((state_q == IDLE) && rd_start) idx <= '0;
      // Stale memory behind a cleared flag is masked here rather than erased.
      if (state_q == FETCH) rd_data <= written[idx] ? mem[idx] : 16'h0000;
      if (hs) begin
        if (last_beat) begin
          written  <= '0;
          fill_cnt <= '0;
          idx      <= '0;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[address[AW-1:0]] <= out;
  end

endmodule

// File: doc/frame_buffer_ctrl.md
FRAME_BUFFER_CTRL -- requirements
Module: frame_buffer_ctrl

Interface
REQ-001 Parameter DEPTH, 64, number of 16-bit buffer entries; power of two, 2..256.
REQ-002 Parameter AW, 6, index width; SHALL equal log2(DEPTH).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-005 load  input  1  upstream write strobe; a write is requested in each cycle it is high.
REQ-006 out  input  16  upstream write data, qualified by load.
REQ-007 address  input  16  upstream write address, qualified by load.
REQ-008 rd_start  input  1  single-cycle request to drain the buffer.
REQ-009 rd_ready  input  1  downstream accepts the current read beat.
REQ-010 rd_valid  output  1  rd_data, rd_index and rd_last are valid.
REQ-011 rd_data  output  16  drained word.
REQ-012 rd_index  output  AW  buffer index of rd_data.
REQ-013 rd_last  output  1  current beat is index DEPTH-1.
REQ-014 busy  output  1  high whenever the FSM is not in IDLE.
REQ-015 done  output  1  one-cycle pulse after the final beat is accepted.
REQ-016 fill_cnt  output  AW+1  number of entries written since the last clear.
REQ-017 drop_cnt  output  8  saturating count of rejected writes.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, FETCH and PRESENT.
REQ-019 In IDLE, load=1 with address<DEPTH SHALL write out into mem[address[AW-1:0]] and set that entry's written flag.
REQ-020 fill_cnt SHALL increment only when the written flag was previously clear; rewriting an entry SHALL leave fill_cnt unchanged.
REQ-021 load=1 with address>=DEPTH, or load=1 in any state other than IDLE, SHALL discard the write and increment drop_cnt, saturating at 255.
REQ-022 rd_start=1 in IDLE SHALL move the FSM to FETCH with read index 0; rd_start SHALL be ignored outside IDLE.
REQ-023 When load and rd_start are both high in one IDLE cycle, the write SHALL complete and SHALL be visible in the drain.
REQ-024 FETCH SHALL last one cycle: it registers mem[index], or 16'h0000 if that entry's written flag is clear, then moves to PRESENT.
REQ-025 In PRESENT, rd_valid=1 and rd_data, rd_index and rd_last SHALL hold stable until rd_valid&&rd_ready.
REQ-026 On a PRESENT handshake with index<DEPTH-1, the FSM SHALL increment the index and return to FETCH.
REQ-027 Throughput is therefore one beat per two cycles when rd_ready is held high.
REQ-028 On a PRESENT handshake with index==DEPTH-1, the FSM SHALL go to IDLE, clear all written flags, zero fill_cnt and pulse done for one cycle.
REQ-029 drop_cnt SHALL never clear on a drain; only reset clears it.
REQ-030 rd_valid SHALL be low in IDLE and FETCH.
REQ-031 busy SHALL be high in FETCH and PRESENT.
REQ-032 The first rd_valid SHALL rise exactly 2 cycles after the cycle rd_start is sampled.
REQ-033 Index arithmetic SHALL be AW bits wide; the index SHALL never wrap past DEPTH-1 within a drain.

Reset
REQ-034 reset SHALL force state IDLE, index 0, all written flags clear, fill_cnt 0, drop_cnt 0, rd_valid 0, rd_data 0, rd_index 0, rd_last 0, busy 0 and done 0.
REQ-035 Memory contents need not clear, because clear written flags mask them to zero on the next drain.
REQ-036 reset SHALL take priority over every other input, including mid-drain, and SHALL abort the drain without asserting done.

Verification
REQ-037 Writes (addr 0, 16'hFFFF), (addr 5, 16'h0000), (addr 5, 16'hFFFF); pulse rd_start; rd_ready=1 -> fill_cnt=2 before drain, then 64 beats: index0=FFFF, index5=FFFF, others 0; rd_last only on beat 63; done at the cycle after beat 63; fill_cnt=0 afterwards.
REQ-038 load=1 with address=100 (DEPTH=64) -> no write, fill_cnt unchanged, drop_cnt=1.
REQ-039 rd_start then load pulses during the drain; 300 rejected writes in total -> drop_cnt saturates at 255; the drained data is unaffected.
REQ-040 rd_ready held low for 5 cycles at beat 3 -> rd_valid stays 1 and rd_data/rd_index remain constant at index 3 throughout.
REQ-041 Assert reset during PRESENT at index 10 -> next cycle busy=0, rd_valid=0, fill_cnt=0, done never pulses; a new rd_start drains all zeros.
REQ-042 Simultaneous load (addr 63, 16'hFFFF) and rd_start in IDLE -> the final beat carries rd_data=FFFF with rd_last=1.
